// File: rtl/lsu_obi.sv
// lsu_obi: registered load/store unit driving an OBI-style data port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses).
module lsu_obi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode_in,
  input  logic [2:0]          funct3,
  input  logic [4:0]          rd_in,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   data_add_in,
  input  logic [DATA_W-1:0]   mem_wdata_in,
  output logic                busy_o,
  output logic                data_req_o,
  output logic                data_we_o,
  output logic [ADDR_W-1:0]   data_add_o,
  output logic [DATA_W/8-1:0] data_be_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_gnt_in,
  input  logic                data_rvalid,
  input  logic [DATA_W-1:0]   data_rdata_in,
  output logic                rd_write,
  output logic [4:0]          rd_out,
  output logic [DATA_W-1:0]   mem_data_out,
  output logic                err_o
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam bit WIDE = (DATA_W == 64);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_n;

  logic is_ld, is_st, legal, trap, take, ok;
  logic [1:0] sz;
  logic [OW-1:0] k_in, amask, k_al, k_q;
  logic [NB-1:0] be_n;
  logic [DATA_W-1:0] wdata_n, lane, ext;
  logic st_q;
  logic [2:0] f3_q;

  assign sz    = funct3[1:0];
  assign is_ld = (opcode_in == 7'b0000011);
  assign is_st = (opcode_in == 7'b0100011);
  assign k_in  = data_add_in[OW-1:0];
  assign k_al  = k_in & ~amask;
  assign take  = (state == IDLE) && mem_valid && (is_ld || is_st);
  assign ok    = take && legal && !trap;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = |(k_in & amask);
`else
  assign trap = 1'b0;
`endif

  // funct3 legality per access kind and bus width
  always_comb begin
    legal = 1'b0;
    if (is_ld) begin
      unique case (funct3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110: legal = WIDE;
        default:        legal = 1'b0;
      endcase
    end else if (is_st) begin
      unique case (funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = WIDE;
        default:                legal = 1'b0;
      endcase
    end
  end

  // alignment mask, byte enables and replicated store data
  always_comb begin
    amask   = '0;
    be_n    = '1;
    wdata_n = mem_wdata_in;
    unique case (sz)
      2'd0: begin
        amask   = '0;
        be_n    = NB'(1) << k_al;
        wdata_n = {NB{mem_wdata_in[7:0]}};
      end
      2'd1: begin
        amask   = OW'(1);
        be_n    = NB'(3) << k_al;
        wdata_n = {(NB/2){mem_wdata_in[15:0]}};
      end
      2'd2: begin
        amask   = OW'(3);
        be_n    = NB'(15) << k_al;
        wdata_n = {(DATA_W/32){mem_wdata_in[31:0]}};
      end
      default: begin
        amask   = '1;
        be_n    = '1;
        wdata_n = mem_wdata_in;
      end
    endcase
  end

  // lane extraction and sign/zero extension of load data
  always_comb begin
    lane = data_rdata_in >> {k_q, 3'b000};
    ext  = lane;
    case (f3_q)
      3'b000:  ext = DATA_W'($signed(lane[7:0]));
      3'b001:  ext = DATA_W'($signed(lane[15:0]));
      3'b010:  ext = DATA_W'($signed(lane[31:0]));
      3'b100:  ext = DATA_W'(lane[7:0]);
      3'b101:  ext = DATA_W'(lane[15:0]);
      3'b110:  ext = DATA_W'(lane[31:0]);
      default: ext = lane;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next state and handshake outputs
  always_comb begin
    state_n    = state;
    busy_o     = (state != IDLE);
    data_req_o = 1'b0;
    data_we_o  = 1'b0;
    rd_write   = 1'b0;
    unique case (state)
      IDLE: if (ok) state_n = REQ;
      REQ: begin
        data_req_o = 1'b1;
        data_we_o  = st_q;
        if (data_gnt_in) state_n = st_q ? IDLE : WAIT;
      end
      WAIT: if (data_rvalid) state_n = RESP;
      RESP: begin
        rd_write = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // request latch, error pulse and load result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_o        <= 1'b0;
      st_q         <= 1'b0;
      f3_q         <= '0;
      k_q          <= '0;
      rd_out       <= '0;
      data_add_o   <= '0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      mem_data_out <= '0;
    end else begin
      err_o <= take && !(legal && !trap);
      if (ok) begin
        st_q         <= is_st;
        f3_q         <= funct3;
        k_q          <= k_al;
        rd_out       <= rd_in;
        data_add_o   <= {data_add_in[ADDR_W-1:OW], {OW{1'b0}}};
        data_be_o    <= be_n;
        data_wdata_o <= wdata_n;
      end
      if (state == WAIT && data_rvalid) mem_data_out <= ext;
    end
  end
endmodule

// File: tb/tb_lsu_obi.sv
// tb_lsu_obi: scoreboard bench for lsu_obi at DATA_W 32 and 64.
// Bus and write-back expectations are queued at issue, popped on output.
module tb_lsu_obi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd_in;
  logic mv32, mv64, gnt, rvalid;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;

  logic busy32, req32, we32, rdw32, err32;
  logic [31:0] add32, wd32, md32;
  logic [3:0] be32;
  logic [4:0] rdo32;
  logic busy64, req64, we64, rdw64, err64;
  logic [31:0] add64;
  logic [63:0] wd64, md64;
  logic [7:0] be64;
  logic [4:0] rdo64;

  bit w64;
  logic busy, req, we, rdw, err;
  logic [31:0] add;
  logic [7:0] be;
  logic [63:0] wdo, md;
  logic [4:0] rdo;
  assign busy = w64 ? busy64 : busy32;
  assign req  = w64 ? req64 : req32;
  assign we   = w64 ? we64 : we32;
  assign rdw  = w64 ? rdw64 : rdw32;
  assign err  = w64 ? err64 : err32;
  assign add  = w64 ? add64 : add32;
  assign be   = w64 ? be64 : {4'h0, be32};
  assign wdo  = w64 ? wd64 : {32'h0, wd32};
  assign md   = w64 ? md64 : {32'h0, md32};
  assign rdo  = w64 ? rdo64 : rdo32;

  lsu_obi #(.ADDR_W(32), .DATA_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .opcode_in(opcode), .funct3(funct3),
    .rd_in(rd_in), .mem_valid(mv32), .data_add_in(addr),
    .mem_wdata_in(wdata[31:0]), .busy_o(busy32), .data_req_o(req32),
    .data_we_o(we32), .data_add_o(add32), .data_be_o(be32),
    .data_wdata_o(wd32), .data_gnt_in(gnt), .data_rvalid(rvalid),
    .data_rdata_in(rdata[31:0]), .rd_write(rdw32), .rd_out(rdo32),
    .mem_data_out(md32), .err_o(err32)
  );

  lsu_obi #(.ADDR_W(32), .DATA_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .opcode_in(opcode), .funct3(funct3),
    .rd_in(rd_in), .mem_valid(mv64), .data_add_in(addr),
    .mem_wdata_in(wdata), .busy_o(busy64), .data_req_o(req64),
    .data_we_o(we64), .data_add_o(add64), .data_be_o(be64),
    .data_wdata_o(wd64), .data_gnt_in(gnt), .data_rvalid(rvalid),
    .data_rdata_in(rdata), .rd_write(rdw64), .rd_out(rdo64),
    .mem_data_out(md64), .err_o(err64)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wd;
  } bus_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] d;
  } wb_t;

  bus_t bq[$];
  wb_t  wq[$];
  logic [63:0] last_md;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal_f(bit ld, logic [2:0] f3, bit wide);
    if (ld)
      return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
             (wide && (f3 inside {3'd3, 3'd6}));
    return (f3 inside {3'd0, 3'd1, 3'd2}) || (wide && f3 == 3'd3);
  endfunction

  function automatic logic [63:0] ld_model(logic [2:0] f3, int ka,
                                           logic [63:0] rv, int nb);
    int sz = 1 << f3[1:0];
    logic [63:0] r = '0;
    for (int i = 0; i < sz; i++) r[8*i +: 8] = rv[8*(ka+i) +: 8];
    if (!f3[2] && r[8*sz-1])
      for (int i = sz; i < nb; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // bus monitor: every granted request must match the oldest expectation
  always @(negedge clk) begin : mon_bus
    bus_t e;
    if (rst_n && (req32 || req64) && gnt) begin
      chk("bus_src", req, 1);
      if (bq.size() == 0) chk("bus_unexp", 1, 0);
      else begin
        e = bq.pop_front();
        chk("bus_add", add, e.a);
        chk("bus_be", be, e.be);
        chk("bus_we", we, e.we);
        if (e.we) chk("bus_wd", wdo, e.wd);
      end
    end
  end

  // write-back monitor
  always @(negedge clk) begin : mon_wb
    wb_t w;
    if (rdw32 || rdw64) begin
      chk("wb_src", rdw, 1);
      last_md = md;
      if (wq.size() == 0) chk("wb_unexp", 1, 0);
      else begin
        w = wq.pop_front();
        chk("wb_rd", rdo, w.rd);
        chk("wb_data", md, w.d);
      end
    end
  end

  task automatic xact(input bit ld, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] a,
                      input logic [63:0] wd, input logic [63:0] rv,
                      input int gdly, input int rdly);
    int nb = w64 ? 8 : 4;
    int sz = 1 << f3[1:0];
    int k = int'(a[2:0]) % nb;
    int ka = k - (k % sz);
    bit lg = legal_f(ld, f3, w64);
    bit trap = 1'b0;
    bus_t e;
    wb_t w;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (k % sz) != 0;
`endif
    e.a = a & ~32'(nb - 1);
    e.be = '0;
    for (int i = 0; i < sz && i < 8; i++) e.be[(ka+i) % 8] = 1'b1;
    e.we = !ld;
    e.wd = '0;
    for (int i = 0; i < nb; i++) e.wd[8*i +: 8] = wd[8*(i % sz) +: 8];
    w.rd = rd;
    w.d = ld_model(f3, ka, w64 ? rv : {32'h0, rv[31:0]}, nb);
    @(posedge clk); #1;
    opcode = ld ? 7'b0000011 : 7'b0100011;
    funct3 = f3; rd_in = rd; addr = a; wdata = wd;
    if (w64) mv64 = 1'b1; else mv32 = 1'b1;
    if (lg && !trap) begin
      bq.push_back(e);
      if (ld) wq.push_back(w);
    end
    @(posedge clk); #1;
    mv32 = 1'b0; mv64 = 1'b0; opcode = '0;
    if (!lg || trap) begin
      chk("err_pulse", err, 1);
      chk("err_noreq", req, 0);
      chk("err_busy", busy, 0);
      @(posedge clk); #1;
      chk("err_clear", err, 0);
      return;
    end
    chk("acc_busy", busy, 1);
    chk("acc_req", req, 1);
    chk("acc_err", err, 0);
    for (int g = 0; g < gdly; g++) begin
      chk("hold_req", req, 1);
      chk("hold_add", add, e.a);
      chk("hold_be", be, e.be);
      if (!ld) chk("hold_wd", wdo, e.wd);
      @(posedge clk); #1;
    end
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    if (!ld) begin
      chk("st_idle", busy, 0);
      chk("st_req", req, 0);
      return;
    end
    chk("ld_wait_req", req, 0);
    chk("ld_wait_busy", busy, 1);
    for (int r = 0; r < rdly; r++) begin
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rdata = rv;
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = {$urandom, $urandom};
    chk("ld_rdw", rdw, 1);
    @(posedge clk); #1;
    chk("ld_done", rdw, 0);
    chk("ld_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; rd_in = '0;
    mv32 = 1'b0; mv64 = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    addr = '0; wdata = '0; rdata = '0; w64 = 1'b0; last_md = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {busy32, busy64}, 0);
    chk("rst_req", {req32, req64, we32, we64}, 0);
    chk("rst_add", {add32, add64}, 0);
    chk("rst_be", {be32, be64}, 0);
    chk("rst_wd32", wd32, 0);
    chk("rst_wd64", wd64, 0);
    chk("rst_md", {md32, md64[31:0]}, 0);
    chk("rst_wb", {rdw32, rdw64, rdo32, rdo64, err32, err64}, 0);
    rst_n = 1'b1;

    xact(1, 3'b000, 5'd7, 32'h103, 0, 64'h80FF_FF00, 0, 0);
    chk("lb_val", last_md, 64'hFFFF_FF80);
    xact(0, 3'b001, 5'd0, 32'h202, 64'h0000_ABCD, 0, 3, 0);
    xact(1, 3'b010, 5'd9, 32'h302, 0, 64'h1234_5678, 0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_val", last_md, 64'h1234_5678);
`endif
    xact(1, 3'b101, 5'd3, 32'h106, 0, 64'hF00D_0000, 1, 2);
    chk("lhu_val", last_md, 64'h0000_F00D);
    xact(1, 3'b001, 5'd4, 32'h102, 0, 64'h8001_0000, 0, 1);
    chk("lh_val", last_md, 64'hFFFF_8001);
    xact(0, 3'b000, 5'd0, 32'h101, 64'h5A, 0, 0, 0);
    xact(0, 3'b010, 5'd0, 32'h400, 64'hDEAD_BEEF, 0, 1, 0);
    xact(1, 3'b011, 5'd5, 32'h500, 0, 64'h1, 0, 0);
    xact(0, 3'b100, 5'd0, 32'h500, 64'h1, 0, 0, 0);

    @(posedge clk); #1;
    opcode = 7'b0110011; mv32 = 1'b1; addr = 32'h600;
    @(posedge clk); #1;
    mv32 = 1'b0; opcode = '0;
    chk("badop_busy", busy, 0);
    chk("badop_req", req, 0);
    chk("badop_err", err, 0);

    @(posedge clk); #1;
    opcode = 7'b0000011; funct3 = 3'b010; rd_in = 5'd11;
    addr = 32'h700; mv32 = 1'b1;
    bq.push_back('{a: 32'h700, be: 8'h0F, we: 1'b0, wd: 64'h0});
    @(posedge clk); #1;
    mv32 = 1'b0; opcode = '0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    chk("rstw_busy_pre", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; rvalid = 1'b1; rdata = 64'hCAFE_F00D;
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("rstw_rdw", rdw, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_out", {add, be, rdo, err, req}, 0);
    chk("rstw_md", md, 0);
    chk("rstw_wd", wdo, 0);
    @(posedge clk); #1;
    chk("rstw_rdw2", rdw, 0);

    w64 = 1'b1;
    xact(1, 3'b110, 5'd12, 32'h1004, 0, 64'h8765_4321_0000_0000, 0, 0);
    chk("lwu_val", last_md, 64'h0000_0000_8765_4321);
    xact(1, 3'b011, 5'd13, 32'h1008, 0, 64'h0123_4567_89AB_CDEF, 1, 1);
    xact(0, 3'b000, 5'd0, 32'h1007, 64'hA5, 0, 0, 0);
    xact(0, 3'b011, 5'd0, 32'h1010, 64'hFEED_FACE_0BAD_BEEF, 0, 2, 0);
    xact(1, 3'b000, 5'd14, 32'h1015, 0, 64'h0000_9A00_0000_0000, 0, 0);
    chk("lb64_val", last_md, 64'hFFFF_FFFF_FFFF_FF9A);
    xact(1, 3'b111, 5'd1, 32'h1000, 0, 0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      w64 = bit'($urandom_range(0, 1));
      xact(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           5'($urandom_range(1, 31)), {20'h0, 12'($urandom)},
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("bq_empty", bq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_obi.md
# lsu_obi

Parametrised, registered load/store unit between the execute stage and the OBI-style data port (req/gnt/rvalid). Successor to the combinational LSU: adds a handshake FSM, one outstanding transaction, a stall output, DATA_W = 32 or 64 with lane steering and sign/zero extension, and misalignment/illegal-funct3 detection. Sits after execute and drives the register-file write port for loads.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data-bus width; legal values 32 or 64
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode_in  in  7  0000011 = load, 0100011 = store; any other value is ignored
- funct3  in  3  access size and signedness (RISC-V encoding)
- rd_in  in  5  load destination register
- mem_valid  in  1  request valid; accepted only when busy_o = 0
- data_add_in  in  ADDR_W  byte address
- mem_wdata_in  in  DATA_W  store data, right-aligned
- busy_o  out  1  FSM not IDLE; upstream holds its request and stalls
- data_req_o, data_we_o  out  1 each  bus request, write enable
- data_add_o  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits = 0)
- data_be_o  out  DATA_W/8  byte enables
- data_wdata_o  out  DATA_W  store data replicated into the target lanes
- data_gnt_in, data_rvalid  in  1 each  grant, read-data valid
- data_rdata_in  in  DATA_W  read data
- rd_write  out  1  one-cycle write-back strobe
- rd_out  out  5  write-back register
- mem_data_out  out  DATA_W  extended load result
- err_o  out  1  one-cycle pulse on a misaligned access or illegal funct3

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: if mem_valid and the opcode is a load or store, latch opcode, funct3, rd, address and wdata. Legal access -> REQ. Illegal access -> stay IDLE and pulse err_o next cycle.
- REQ: data_req_o = 1. Address, we, be and wdata are held stable until data_gnt_in. On grant, a store -> IDLE and a load -> WAIT.
- WAIT: on data_rvalid, register the extracted result -> RESP.
- RESP: rd_write = 1 with mem_data_out and rd_out valid for exactly one cycle -> IDLE.
- funct3 legality:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU: always legal.
  - 011 LD/SD and 110 LWU: legal only when DATA_W = 64.
  - Stores use 000, 001, 010 and, at DATA_W = 64, 011.
  - All other values are illegal.
- Lane offset k = address modulo (DATA_W/8).
- Byte enables: one-hot at k for a byte, 2'b11 at k for a half, 4'hF at k for a word, all ones for a double.
- Stores: byte/half/word data is replicated across the whole bus.
- Loads: take the addressed lane of data_rdata_in and sign-extend (signed funct3) or zero-extend (U variants) to DATA_W.
- Misaligned means k is not a multiple of the access size.
- busy_o = (state != IDLE). data_rvalid outside WAIT and data_gnt_in outside REQ are ignored.

## Timing
- Reset (rst_n = 0 at an edge): state = IDLE; every output is 0, including data_add_o, data_be_o, data_wdata_o and mem_data_out. Reset mid-transaction abandons it with no write-back, and a late rvalid after reset is ignored.
- Store: accept at cycle 0, data_req_o from cycle 1, complete in the grant cycle. With zero-wait grant, busy_o is high for 1 cycle.
- Load: accept at cycle 0, req at cycle 1, gnt at cycle 1, rvalid at cycle 2, rd_write at cycle 3. Minimum latency is 3 cycles; busy_o is high for cycles 1-3.
- A new request may be accepted in the cycle after the FSM returns to IDLE. This gives back-to-back throughput of one transaction per 2 cycles for stores and 4 for loads.
- Only one transaction is outstanding; the next data_req_o never rises before the prior rvalid.
- Stall on grant: the request holds any number of cycles with all bus outputs unchanged.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access issues no bus request.
  - err_o pulses one cycle after acceptance and rd_write stays 0.
- LSU_MISALIGN_TRAP_EN undefined:
  - The low address bits are forced down to the access-size alignment and the access proceeds normally.
  - err_o fires only for an illegal funct3.

## Test plan
- DATA_W = 32: LB at address 0x103, rdata 0x80FF_FF00, zero-wait gnt, rvalid next cycle -> rd_write at cycle 3, mem_data_out = 0xFFFF_FF80.
- SH at address 0x202, wdata 0x0000_ABCD, gnt delayed 3 cycles -> data_be_o = 0b1100, data_wdata_o = 0xABCD_ABCD, request held stable for 4 cycles, busy_o deasserts after the grant.
- DATA_W = 64: LWU at address 0x…4, rdata 0x8765_4321_0000_0000 -> mem_data_out = 0x0000_0000_8765_4321.
- LW at address 0x…2:
  - With LSU_MISALIGN_TRAP_EN: no data_req_o, err_o pulse, no rd_write.
  - Without it: request to 0x…0 with be = 4'hF and a normal write-back.
- Reset asserted in WAIT, then rvalid arrives -> no rd_write, outputs 0, FSM in IDLE.
- mem_valid with opcode 0110011, and DATA_W = 32 with funct3 011 -> no bus activity. funct3 011 additionally gives an err_o pulse.
